// File: rtl/sobel_edge_if.sv
// sobel_edge_if: pixel stream in, edge results out, for the Sobel stage
interface sobel_edge_if;
  logic din_valid;
  logic [7:0] din;
  logic [11:0] img_width;
  logic [11:0] img_height;
  logic [7:0] threshold;
  logic dout_valid;
  logic [7:0] edge_mag;
  logic edge_bin;
  logic frame_done;
  modport master (
    output din_valid, din, img_width, img_height, threshold,
    input dout_valid, edge_mag, edge_bin, frame_done
  );
  modport slave (
    input din_valid, din, img_width, img_height, threshold,
    output dout_valid, edge_mag, edge_bin, frame_done
  );
endinterface

// File: rtl/sobel_edge.sv
// sobel_edge: streaming 3x3 Sobel gradient magnitude with thresholded edge flag
module sobel_edge #(
  parameter int MAX_WIDTH = 1024
) (
  input logic clk,
  input logic rst,
  sobel_edge_if.slave s
);
  localparam int AW = $clog2(MAX_WIDTH);
  logic [11:0] col, row, w_r, h_r, w_in, h_in;
  logic last_col, last_row;
  logic s0_acc, s0_v, s0_f, s1_v, s1_f, s2_v, s2_f;
  logic [7:0] din_q;
  logic [AW-1:0] col_q;
  logic [7:0] lb0 [MAX_WIDTH];
  logic [7:0] lb1 [MAX_WIDTH];
  logic [7:0] p [3][3];
  logic [9:0] xr, xl, yb, yt;
  logic signed [10:0] gx_n, gy_n, gx, gy;
  logic [10:0] ax, ay, sum;
  logic [7:0] mag_n, mag_q;
  logic bin_q, dv_q, fd_q;
  assign w_in = s.img_width < 12'd3 ? 12'd3 : s.img_width > 12'(MAX_WIDTH) ? 12'(MAX_WIDTH) : s.img_width;
  assign h_in = s.img_height < 12'd3 ? 12'd3 : s.img_height;
  assign last_col = col == w_r - 12'd1;
  assign last_row = row == h_r - 12'd1;
  assign xr = {2'b0, p[0][2]} + {1'b0, p[1][2], 1'b0} + {2'b0, p[2][2]};
  assign xl = {2'b0, p[0][0]} + {1'b0, p[1][0], 1'b0} + {2'b0, p[2][0]};
  assign yb = {2'b0, p[2][0]} + {1'b0, p[2][1], 1'b0} + {2'b0, p[2][2]};
  assign yt = {2'b0, p[0][0]} + {1'b0, p[0][1], 1'b0} + {2'b0, p[0][2]};
  assign gx_n = $signed({1'b0, xr}) - $signed({1'b0, xl});
  assign gy_n = $signed({1'b0, yb}) - $signed({1'b0, yt});
  assign ax = gx[10] ? 11'(-gx) : 11'(gx);
  assign ay = gy[10] ? 11'(-gy) : 11'(gy);
  assign sum = ax + ay;
  assign mag_n = |sum[10:8] ? 8'hff : sum[7:0];
  assign s.dout_valid = dv_q;
  assign s.edge_mag = mag_q;
  assign s.edge_bin = bin_q;
  assign s.frame_done = fd_q;
  // raster counters and frame geometry; tags each accepted pixel as window-complete / frame-last
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      w_r <= 12'd3;
      h_r <= 12'd3;
      s0_acc <= 1'b0;
      s0_v <= 1'b0;
      s0_f <= 1'b0;
    end else begin
      s0_acc <= s.din_valid;
      s0_v <= s.din_valid && row >= 12'd2 && col >= 12'd2;
      s0_f <= s.din_valid && last_row && last_col;
      if (s.din_valid) begin
        if (row == '0 && col == '0) begin
          w_r <= w_in;
          h_r <= h_in;
        end
        col <= last_col ? '0 : col + 12'd1;
        row <= last_col ? (last_row ? '0 : row + 12'd1) : row;
      end
    end
  // line buffers and window shift; contents need no reset since the output gate hides stale data
  always_ff @(posedge clk) begin
    din_q <= s.din;
    col_q <= col[AW-1:0];
    if (s0_acc) begin
      lb1[col_q] <= din_q;
      lb0[col_q] <= lb1[col_q];
      p[0][0] <= p[0][1];
      p[0][1] <= p[0][2];
      p[1][0] <= p[1][1];
      p[1][1] <= p[1][2];
      p[2][0] <= p[2][1];
      p[2][1] <= p[2][2];
      p[0][2] <= lb0[col_q];
      p[1][2] <= lb1[col_q];
      p[2][2] <= din_q;
    end
  end
  // gradient register stage
  always_ff @(posedge clk) begin
    gx <= gx_n;
    gy <= gy_n;
  end
  // valid/last tags follow the data; outputs hold when no result is produced
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_f <= 1'b0;
      s2_v <= 1'b0;
      s2_f <= 1'b0;
      dv_q <= 1'b0;
      fd_q <= 1'b0;
      mag_q <= '0;
      bin_q <= 1'b0;
    end else begin
      s1_v <= s0_v;
      s1_f <= s0_f;
      s2_v <= s1_v;
      s2_f <= s1_f;
      dv_q <= s2_v;
      fd_q <= s2_f;
      if (s2_v) begin
        mag_q <= mag_n;
        bin_q <= mag_n >= s.threshold;
      end
    end
endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: table-driven frames with scoreboarded outputs, plus a mid-frame reset sequence
module tb_sobel_edge;
  typedef struct {
    int w, h, kind, a, b, split, thr, gap, tog, exp_n;
    logic [63:0] ct, rt;
  } vec_t;
  typedef struct {
    int tag;
    logic [7:0] mag;
    logic bin, fd;
    int acc;
  } exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, n_chk = 0, n_err = 0;
  int cnt[8] = '{default: 0};
  int fdc[8] = '{default: 0};
  vec_t vec[7];
  exp_t q[$];
  exp_t e;
  sobel_edge_if bus();
  sobel_edge dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] pix_val(input vec_t v, input int r, input int c);
    int x;
    x = v.kind == 1 ? (c < v.split ? v.a : v.b) : v.kind == 2 ? (r < v.split ? v.a : v.b) : v.a;
    return 8'(x);
  endfunction
  task automatic idle();
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
  endtask
  task automatic run_frame(input int ri, input int tag, input int maxpix);
    vec_t v;
    int k;
    v = vec[ri];
    k = 0;
    for (int r = 0; r < v.h; r++)
      for (int c = 0; c < v.w; c++) begin
        logic [7:0] m;
        if (k < maxpix) begin
          if (v.gap != 0)
            while ($urandom_range(0, 1) == 1) idle();
          @(posedge clk);
          #1;
          bus.din_valid = 1'b1;
          if (r == 0 && c == 0) begin
            bus.img_width = 12'(v.w);
            bus.img_height = 12'(v.h);
            bus.threshold = 8'(v.thr);
          end
          if (v.tog != 0 && r == 2 && c == 0) bus.img_width = 12'(v.tog);
          bus.din = pix_val(v, r, c);
          if (tag >= 0 && r >= 2 && c >= 2) begin
            m = v.ct[8*(c-1) +: 8] | v.rt[8*(r-1) +: 8];
            q.push_back('{tag: tag, mag: m, bin: (m >= 8'(v.thr)), fd: (r == v.h-1 && c == v.w-1), acc: cyc + 1});
          end
        end
        k++;
      end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bus.dout_valid) begin
        chk("output_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("edge_mag", 32'(bus.edge_mag), 32'(e.mag));
          chk("edge_bin", 32'(bus.edge_bin), 32'(e.bin));
          chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
          chk("latency", cyc, e.acc + 3);
          cnt[e.tag]++;
          fdc[e.tag] += int'(bus.frame_done);
        end
      end else if (bus.frame_done)
        chk("frame_done_without_valid", 32'(bus.frame_done), 0);
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec[0] = '{w: 8, h: 6, kind: 0, a: 100, b: 0, split: 0, thr: 1, gap: 0, tog: 0, exp_n: 24, ct: 64'h0, rt: 64'h0};
    vec[1] = '{w: 8, h: 5, kind: 1, a: 0, b: 200, split: 4, thr: 128, gap: 0, tog: 0, exp_n: 18, ct: 64'h00_00_00_ff_ff_00_00_00, rt: 64'h0};
    vec[2] = '{w: 6, h: 6, kind: 2, a: 50, b: 60, split: 3, thr: 40, gap: 0, tog: 0, exp_n: 16, ct: 64'h0, rt: 64'h00_00_00_00_28_28_00_00};
    vec[3] = '{w: 6, h: 6, kind: 2, a: 50, b: 60, split: 3, thr: 41, gap: 0, tog: 0, exp_n: 16, ct: 64'h0, rt: 64'h00_00_00_00_28_28_00_00};
    vec[4] = '{w: 8, h: 5, kind: 1, a: 0, b: 200, split: 4, thr: 128, gap: 1, tog: 0, exp_n: 18, ct: 64'h00_00_00_ff_ff_00_00_00, rt: 64'h0};
    vec[5] = '{w: 8, h: 5, kind: 2, a: 10, b: 20, split: 2, thr: 40, gap: 0, tog: 5, exp_n: 18, ct: 64'h0, rt: 64'h00_00_00_00_00_28_28_00};
    vec[6] = '{w: 5, h: 5, kind: 1, a: 0, b: 200, split: 2, thr: 128, gap: 0, tog: 8, exp_n: 9, ct: 64'h00_00_00_00_00_ff_ff_00, rt: 64'h0};
    bus.din_valid = 1'b0;
    bus.din = '0;
    bus.img_width = 12'd8;
    bus.img_height = 12'd6;
    bus.threshold = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout_valid", 32'(bus.dout_valid), 0);
    chk("reset_edge_mag", 32'(bus.edge_mag), 0);
    chk("reset_edge_bin", 32'(bus.edge_bin), 0);
    chk("reset_frame_done", 32'(bus.frame_done), 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run_frame(i, i, 1 << 30);
    repeat (10) idle();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("output_count_vec%0d", i), cnt[i], vec[i].exp_n);
      chk($sformatf("frame_done_count_vec%0d", i), fdc[i], 1);
    end
    run_frame(0, -1, 20);
    @(posedge clk);
    #2 rst = 1'b1;
    bus.din_valid = 1'b0;
    #1;
    chk("async_reset_dout_valid", 32'(bus.dout_valid), 0);
    chk("async_reset_edge_mag", 32'(bus.edge_mag), 0);
    chk("async_reset_frame_done", 32'(bus.frame_done), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(0, 7, 1 << 30);
    repeat (10) idle();
    chk("output_count_after_reset", cnt[7], 24);
    chk("frame_done_count_after_reset", fdc[7], 1);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sobel_edge.md
# sobel_edge

Streaming 3x3 Sobel edge detector that sits directly downstream of the image pre-processing stage. It consumes the Gaussian-smoothed 8-bit grayscale pixel stream in raster order and produces, per interior pixel, a saturated gradient magnitude plus a thresholded binary edge flag for the feature-extraction stage. Two internal line buffers and a 3x3 window register array form the window. A fixed 3-cycle valid-tagged pipeline computes the result, with no backpressure.

## Interface
- MAX_WIDTH, 1024: line buffer depth; largest supported image width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din_valid  input  1  pixel strobe; din is accepted on every rising edge where high.
- din  input  8  grayscale pixel, raster order.
- img_width  input  12  pixels per line; latched at frame start.
- img_height  input  12  lines per frame; latched at frame start.
- threshold  input  8  edge threshold; sampled in stage 3 each cycle.
- dout_valid  output  1  edge_mag/edge_bin valid this cycle.
- edge_mag  output  8  min(|Gx|+|Gy|, 255).
- edge_bin  output  1  edge_mag >= threshold.
- frame_done  output  1  one-cycle pulse coincident with the last output of a frame.

## Operation
- Counters col and row (12 bit) advance only on accepted pixels.
- Wrap rules:
  - col == W-1: col goes to 0 and row increments.
  - col == W-1 and row == H-1: row goes to 0 (frame end).
- Frame start is an accepted pixel with row==0, col==0. On that pixel, W and H are latched from img_width/img_height.
  - W is clamped to [3, MAX_WIDTH]; H is clamped to a minimum of 3.
  - Changes to these inputs mid-frame are ignored.
- Line buffers: LB1 holds row r-1 and LB0 holds row r-2, both addressed by col. On each accepted pixel:
  - read LB1[col] and LB0[col];
  - write LB1[col] <= din and LB0[col] <= old LB1[col].
- Window: on each accepted pixel, the three columns shift left and the new right column {LB0[col], LB1[col], din} is inserted. The window center is pixel (row-1, col-1).
- An output is emitted only when row >= 2 and col >= 2. This gives (W-2)*(H-2) outputs per frame, with no border padding. Stale window columns at line start are discarded by this gate.
- Arithmetic, with pRC meaning window row R and column C, where 0 is top/left:
  - Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20).
  - Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02).
  - Partial sums are 10-bit unsigned. Gx and Gy are 11-bit signed, range ±1020.
  - The magnitude sum is 11 bits wide (max 2040) and saturates to 255.
- Pipeline:
  - S1: window and counters update.
  - S2: Gx and Gy are registered.
  - S3: abs, sum, saturate and compare, all registered to the outputs.
  - Each stage carries a valid bit and advances every clock regardless of din_valid.
- frame_done travels with the pipeline alongside the output for window center (H-2, W-2).
- Line buffer contents are not reset. They are never used before being written within a frame.

## Timing
- Reset values: dout_valid=0, edge_mag=0, edge_bin=0, frame_done=0. Counters and pipeline valids are 0, and the latched W and H are 3.
- Reset is asynchronous and effective immediately. Any in-flight results are dropped, and the next accepted pixel is treated as row 0, col 0.
- Latency: a pixel accepted at rising edge t that completes a window causes dout_valid to be high in the cycle following edge t+3.
- Gaps in din_valid produce gaps in dout_valid but do not change latency.
- Throughput is one pixel per clock, with no stall input.
- Output ports hold their last values when dout_valid is 0. Only the valid-qualified values are checked.

## Test plan
- Flat frame, 8x6, all pixels 100, threshold 1:
  - exactly 24 outputs, all edge_mag=0 and edge_bin=0;
  - a single frame_done, asserted on the 24th output.
- Vertical step, W=8, H=5, columns 0-3 = 0, columns 4-7 = 200, threshold 128:
  - each of the 3 output rows produces centers 1..6;
  - centers 3 and 4 give mag 255 and bin 1 (Gx = 800);
  - all other centers give mag 0 and bin 0.
- Horizontal step, W=6, H=6, rows 0-2 = 50, rows 3-5 = 60:
  - center rows 2 and 3 give mag 40 (Gy = 40);
  - center rows 1 and 4 give mag 0;
  - with threshold 40, bin=1 on rows 2 and 3; with threshold 41, bin=0 everywhere.
- Repeat the vertical step with random 50% idle din_valid:
  - the output sequence must be identical;
  - each dout_valid must appear exactly 3 cycles after its completing input.
- Reset pulse after 20 pixels of an 8x6 frame, then a full flat frame: exactly 24 outputs, all correct, and one frame_done.
- Back-to-back frames at 8x5 then 5x5, with img_width toggled mid-frame:
  - the output counts are 18 and 9;
  - the mid-frame change has no effect;
  - frame_done fires twice.
